// File: rtl/spi_master_cfg_if.sv
// Command-side bus of spi_master_cfg: one command per valid/ready handshake,
// plus the read-data return path.
interface spi_master_cfg_if #(
  parameter int CMD_WIDTH  = 12,
  parameter int READ_WIDTH = 8,
  parameter int CS_W       = 1
);
  logic [CMD_WIDTH-1:0]  cmd_in;
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [CS_W-1:0]       cs_sel;
  logic [1:0]            mode;
  logic                  busy;
  logic                  read_vld;
  logic [READ_WIDTH-1:0] read_data;

  modport master (
    output cmd_in, cmd_vld, cs_sel, mode,
    input  cmd_rdy, busy, read_vld, read_data
  );

  modport slave (
    input  cmd_in, cmd_vld, cs_sel, mode,
    output cmd_rdy, busy, read_vld, read_data
  );
endinterface

// File: rtl/spi_master_cfg.sv
// SPI master for register-style slaves: write or read frames with runtime
// CPOL/CPHA, programmable SCLK divider and per-command chip-select choice.
module spi_master_cfg #(
  parameter int CMD_WIDTH  = 12,
  parameter int ADDR_BITS  = 4,
  parameter int READ_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int NUM_CS     = 2,
  parameter int CS_W       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_cfg_if.slave   bus,
  output logic              o_sclk,
  output logic [NUM_CS-1:0] o_cs_n,
  output logic              o_mosi,
  input  logic              i_miso
);

  localparam int RD_BITS = ADDR_BITS + READ_WIDTH;
  localparam int TXW     = (CMD_WIDTH > RD_BITS) ? CMD_WIDTH : RD_BITS;
  localparam int HW      = $clog2(2 * TXW);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_WR  = HW'(2 * CMD_WIDTH - 1);
  localparam logic [HW-1:0] HALF_RD  = HW'(2 * RD_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t                r_state;
  logic [DW-1:0]         r_div;
  logic [HW-1:0]         r_half;
  logic [HW-1:0]         r_half_last;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_is_write;
  logic [TXW-1:0]        r_tx;
  logic [READ_WIDTH-1:0] r_rx;
  logic [NUM_CS-1:0]     r_cs_n;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_rdy;
  logic                  r_busy;
  logic                  r_read_vld;
  logic [READ_WIDTH-1:0] r_read_data;

  logic                  w_accept;
  logic                  w_div_end;
  logic [TXW-1:0]        w_tx_load;
  logic [NUM_CS-1:0]     w_cs_n_sel;

  assign w_accept  = bus.cmd_vld && r_rdy;
  assign w_div_end = (r_div == DIV_LAST);

  // Outgoing bits left-aligned; a read frame carries only its header, then zeros.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_tx_load = '0;
    if (bus.cmd_in[CMD_WIDTH-1])
      w_tx_load[TXW-1 -: CMD_WIDTH] = bus.cmd_in;
    else
      w_tx_load[TXW-1 -: ADDR_BITS] = bus.cmd_in[CMD_WIDTH-1 -: ADDR_BITS];
  end

  // An out-of-range cs_sel matches no line, so the frame runs with all selects high.
  always_comb begin
    w_cs_n_sel = '1;
    for (int i = 0; i < NUM_CS; i++)
      w_cs_n_sel[i] = (bus.cs_sel != CS_W'(i));
  end

  // NOTE: async active-low reset, and all state updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_half      <= '0;
      r_half_last <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_is_write  <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cs_n      <= '1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_rdy       <= 1'b1;
      r_busy      <= 1'b0;
      r_read_vld  <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_read_vld <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state     <= S_SETUP;
          r_div       <= '0;
          r_rdy       <= 1'b0;
          r_busy      <= 1'b1;
          r_cpol      <= bus.mode[1];
          r_cpha      <= bus.mode[0];
          r_sclk      <= bus.mode[1];
          r_is_write  <= bus.cmd_in[CMD_WIDTH-1];
          r_half_last <= bus.cmd_in[CMD_WIDTH-1] ? HALF_WR : HALF_RD;
          r_cs_n      <= w_cs_n_sel;
          // CPHA=0 presents the first bit before any clock edge.
          if (bus.mode[0]) begin
            r_mosi <= 1'b0;
            r_tx   <= w_tx_load;
          end else begin
            r_mosi <= w_tx_load[TXW-1];
            r_tx   <= w_tx_load << 1;
          end
        end
        S_SETUP: if (w_div_end) begin
          r_state <= S_SHIFT;
          r_div   <= '0;
          r_half  <= '0;
          r_sclk  <= ~r_cpol;
          if (r_cpha) begin
            r_mosi <= r_tx[TXW-1];
            r_tx   <= r_tx << 1;
          end else begin
            r_rx <= {r_rx[READ_WIDTH-2:0], i_miso};
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
        S_SHIFT: if (w_div_end) begin
          r_div <= '0;
          if (r_half == r_half_last) begin
            r_state <= S_HOLD;
            r_mosi  <= 1'b0;
          end else begin
            r_half <= r_half + 1'b1;
            r_sclk <= ~r_sclk;
            // Odd r_half means the edge about to happen is a leading edge.
            // Header samples fall off the top of r_rx, leaving only data bits.
            if (r_half[0] ^ r_cpha) begin
              r_rx <= {r_rx[READ_WIDTH-2:0], i_miso};
            end else begin
              r_mosi <= r_tx[TXW-1];
              r_tx   <= r_tx << 1;
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
        S_HOLD: if (w_div_end) begin
          r_state <= S_GAP;
          r_div   <= '0;
          r_cs_n  <= '1;
          if (!r_is_write) begin
            r_read_vld  <= 1'b1;
            r_read_data <= r_rx;
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
        S_GAP: if (w_div_end) begin
          r_state <= S_IDLE;
          r_div   <= '0;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
        end else begin
          r_div <= r_div + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy   = r_rdy;
  assign bus.busy      = r_busy;
  assign bus.read_vld  = r_read_vld;
  assign bus.read_data = r_read_data;
  assign o_sclk        = r_sclk;
  assign o_cs_n        = r_cs_n;
  assign o_mosi        = r_mosi;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: a behavioural SPI slave/monitor on the
// pins, compared against frame-level expectations derived from the command word.
module tb_spi_master_cfg;

  localparam int CMD_WIDTH  = 12;
  localparam int ADDR_BITS  = 4;
  localparam int READ_WIDTH = 8;
  localparam int CLK_DIV    = 2;
  localparam int NUM_CS     = 2;
  localparam int CS_W       = 2;
  localparam int BOUND      = 400;

  logic              clk;
  logic              rst_n;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_cfg_if #(.CMD_WIDTH(CMD_WIDTH), .READ_WIDTH(READ_WIDTH), .CS_W(CS_W)) bus ();

  spi_master_cfg #(
    .CMD_WIDTH(CMD_WIDTH), .ADDR_BITS(ADDR_BITS), .READ_WIDTH(READ_WIDTH),
    .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS), .CS_W(CS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o_sclk(sclk), .o_cs_n(cs_n), .o_mosi(mosi), .i_miso(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame observations collected by run_frame.
  int                    obs_wait, obs_lead, obs_trail, obs_rdy_at;
  int                    obs_rvld_cnt, obs_rvld_at, obs_cs_tail, obs_busy_bad;
  int                    obs_cs_low [NUM_CS];
  logic [31:0]           obs_mosi;
  logic [READ_WIDTH-1:0] obs_rdata;
  logic                  obs_sclk_first, obs_sclk_last, obs_rdy_first, obs_mosi_last;
  logic [READ_WIDTH-1:0] exp_rdata;

  // Reference model: frame length, expected mosi stream and timing from the rules.
  function automatic int model_n(input logic [CMD_WIDTH-1:0] c);
    return c[CMD_WIDTH-1] ? CMD_WIDTH : ADDR_BITS + READ_WIDTH;
  endfunction

  function automatic logic [31:0] model_mosi(input logic [CMD_WIDTH-1:0] c);
    if (c[CMD_WIDTH-1]) return 32'(c);
    return 32'(c[CMD_WIDTH-1 -: ADDR_BITS]) << READ_WIDTH;
  endfunction

  function automatic int model_cs_low(input int n);
    return CLK_DIV * (2 + 2 * n);
  endfunction

  function automatic int model_rdy_at(input int n);
    return CLK_DIV * (3 + 2 * n) + 1;
  endfunction

  // Drives one command and acts as the SPI slave until cmd_rdy returns.
  task automatic run_frame(input logic [CMD_WIDTH-1:0] cmd, input logic [1:0] md,
                           input logic [CS_W-1:0] sel, input logic [READ_WIDTH-1:0] sdata,
                           input bit hold);
    bit   q[$];
    logic prev;
    bit   cs_seen_low;
    int   n;
    n = model_n(cmd);
    if (cmd[CMD_WIDTH-1]) begin
      for (int i = 0; i < n; i++) q.push_back(1'($urandom));
    end else begin
      for (int i = 0; i < ADDR_BITS; i++) q.push_back(1'($urandom));
      for (int i = READ_WIDTH - 1; i >= 0; i--) q.push_back(sdata[i]);
    end
    obs_wait = 0; obs_lead = 0; obs_trail = 0; obs_rdy_at = 0;
    obs_rvld_cnt = 0; obs_rvld_at = 0; obs_cs_tail = 0; obs_busy_bad = 0;
    for (int i = 0; i < NUM_CS; i++) obs_cs_low[i] = 0;
    obs_mosi = '0; obs_rdata = '0; cs_seen_low = 1'b0;
    bus.cmd_in = cmd; bus.mode = md; bus.cs_sel = sel; bus.cmd_vld = 1'b1;
    while (bus.cmd_rdy !== 1'b1 && obs_wait < BOUND) begin
      @(negedge clk);
      obs_wait++;
    end
    @(negedge clk);
    if (!hold) bus.cmd_vld = 1'b0;
    bus.mode   = 2'($urandom);
    bus.cs_sel = CS_W'($urandom);
    prev = md[1];
    for (int c = 1; c <= BOUND; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        obs_sclk_first = sclk;
        obs_rdy_first  = bus.cmd_rdy;
        if (!md[0]) miso = (q.size() > 0) ? q.pop_front() : 1'b0;
      end
      if (bus.busy !== ~bus.cmd_rdy) obs_busy_bad++;
      for (int i = 0; i < NUM_CS; i++) if (cs_n[i] === 1'b0) obs_cs_low[i]++;
      if (cs_n !== '1) cs_seen_low = 1'b1;
      else if (cs_seen_low) obs_cs_tail++;
      if (sclk !== prev) begin
        if (prev === md[1]) begin
          obs_lead++;
          if (md[0]) miso = (q.size() > 0) ? q.pop_front() : 1'b0;
          else       obs_mosi = {obs_mosi[30:0], mosi};
        end else begin
          obs_trail++;
          if (md[0]) obs_mosi = {obs_mosi[30:0], mosi};
          else       miso = (q.size() > 0) ? q.pop_front() : 1'b0;
        end
      end
      prev = sclk;
      if (bus.read_vld === 1'b1) begin
        obs_rvld_cnt++;
        obs_rvld_at = c;
        obs_rdata   = bus.read_data;
      end
      if (bus.cmd_rdy === 1'b1) begin
        obs_rdy_at    = c;
        obs_sclk_last = sclk;
        obs_mosi_last = mosi;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy: got %b expected 1", bus.cmd_rdy); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 11", cs_n); end
    n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    n_tests++; if (bus.read_vld !== 1'b0) begin n_fail++; $display("FAIL reset_read_vld: got %b expected 0", bus.read_vld); end
    n_tests++; if (bus.read_data !== 8'h00) begin n_fail++; $display("FAIL reset_read_data: got %h expected 00", bus.read_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_mode0;
    run_frame(12'hA5C, 2'b00, 2'd0, 8'h00, 1'b0);
    n_tests++; if (obs_mosi !== 32'hA5C) begin n_fail++; $display("FAIL wr_mosi: got %h expected a5c", obs_mosi); end
    n_tests++; if (obs_lead !== 12 || obs_trail !== 12) begin n_fail++; $display("FAIL wr_edges: got %0d/%0d expected 12/12", obs_lead, obs_trail); end
    n_tests++; if (obs_cs_low[0] !== 52 || obs_cs_low[1] !== 0) begin n_fail++; $display("FAIL wr_cs_low: got %0d/%0d expected 52/0", obs_cs_low[0], obs_cs_low[1]); end
    n_tests++; if (obs_rdy_at !== 55) begin n_fail++; $display("FAIL wr_rdy_at: got %0d expected 55", obs_rdy_at); end
    n_tests++; if (obs_rdy_first !== 1'b0) begin n_fail++; $display("FAIL wr_rdy_drop: got %b expected 0", obs_rdy_first); end
    n_tests++; if (obs_rvld_cnt !== 0) begin n_fail++; $display("FAIL wr_no_rvld: got %0d expected 0", obs_rvld_cnt); end
    n_tests++; if (bus.read_data !== exp_rdata) begin n_fail++; $display("FAIL wr_rdata_kept: got %h expected %h", bus.read_data, exp_rdata); end
    n_tests++; if (obs_sclk_first !== 1'b0 || obs_sclk_last !== 1'b0) begin n_fail++; $display("FAIL wr_sclk_idle: got %b/%b expected 0/0", obs_sclk_first, obs_sclk_last); end
  endtask

  task automatic test_read_mode0;
    run_frame(12'h3FF, 2'b00, 2'd0, 8'hC3, 1'b0);
    exp_rdata = 8'hC3;
    n_tests++; if (obs_mosi !== 32'h300) begin n_fail++; $display("FAIL rd_mosi: got %h expected 300", obs_mosi); end
    n_tests++; if (obs_rvld_cnt !== 1) begin n_fail++; $display("FAIL rd_rvld_cnt: got %0d expected 1", obs_rvld_cnt); end
    n_tests++; if (obs_rdata !== 8'hC3) begin n_fail++; $display("FAIL rd_data: got %h expected c3", obs_rdata); end
    n_tests++; if (obs_rvld_at !== 53) begin n_fail++; $display("FAIL rd_rvld_at: got %0d expected 53", obs_rvld_at); end
    n_tests++; if (bus.read_data !== 8'hC3) begin n_fail++; $display("FAIL rd_data_held: got %h expected c3", bus.read_data); end
  endtask

  task automatic test_mode3_read;
    logic [CMD_WIDTH-1:0] cmd;
    cmd = {1'b0, 11'($urandom)};
    run_frame(cmd, 2'b11, 2'd0, 8'h5A, 1'b0);
    exp_rdata = 8'h5A;
    n_tests++; if (obs_sclk_first !== 1'b1 || obs_sclk_last !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_idle: got %b/%b expected 1/1", obs_sclk_first, obs_sclk_last); end
    n_tests++; if (obs_lead !== 12 || obs_trail !== 12) begin n_fail++; $display("FAIL m3_edges: got %0d/%0d expected 12/12", obs_lead, obs_trail); end
    n_tests++; if (obs_mosi !== model_mosi(cmd)) begin n_fail++; $display("FAIL m3_mosi: got %h expected %h", obs_mosi, model_mosi(cmd)); end
    n_tests++; if (obs_rdata !== 8'h5A || obs_rvld_cnt !== 1) begin n_fail++; $display("FAIL m3_data: got %h x%0d expected 5a x1", obs_rdata, obs_rvld_cnt); end
  endtask

  task automatic test_cs_select;
    logic [CMD_WIDTH-1:0] cmd;
    cmd = {1'b1, 11'($urandom)};
    run_frame(cmd, 2'b01, 2'd1, 8'h00, 1'b0);
    n_tests++; if (obs_cs_low[0] !== 0 || obs_cs_low[1] !== 52) begin n_fail++; $display("FAIL cs1_low: got %0d/%0d expected 0/52", obs_cs_low[0], obs_cs_low[1]); end
    run_frame(cmd, 2'b10, 2'd3, 8'h00, 1'b0);
    n_tests++; if (obs_cs_low[0] !== 0 || obs_cs_low[1] !== 0) begin n_fail++; $display("FAIL cs3_none: got %0d/%0d expected 0/0", obs_cs_low[0], obs_cs_low[1]); end
    n_tests++; if (obs_rdy_at !== 55) begin n_fail++; $display("FAIL cs3_timed: got %0d expected 55", obs_rdy_at); end
    n_tests++; if (obs_mosi !== model_mosi(cmd)) begin n_fail++; $display("FAIL cs3_mosi: got %h expected %h", obs_mosi, model_mosi(cmd)); end
  endtask

  task automatic test_back_to_back;
    logic [CMD_WIDTH-1:0] c1, c2;
    int tail1, rdy1;
    c1 = {1'b1, 11'($urandom)};
    c2 = {1'b1, 11'($urandom)};
    run_frame(c1, 2'b00, 2'd0, 8'h00, 1'b1);
    tail1 = obs_cs_tail;
    rdy1  = obs_rdy_at;
    run_frame(c2, 2'b00, 2'd0, 8'h00, 1'b0);
    n_tests++; if (rdy1 !== 55) begin n_fail++; $display("FAIL b2b_first_len: got %0d expected 55", rdy1); end
    n_tests++; if (tail1 < CLK_DIV) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d expected >= %0d", tail1, CLK_DIV); end
    n_tests++; if (obs_wait !== 0) begin n_fail++; $display("FAIL b2b_accept: got %0d wait expected 0", obs_wait); end
    n_tests++; if (obs_mosi !== model_mosi(c2)) begin n_fail++; $display("FAIL b2b_mosi: got %h expected %h", obs_mosi, model_mosi(c2)); end
  endtask

  task automatic test_random;
    logic [CMD_WIDTH-1:0]  cmd;
    logic [1:0]            md;
    logic [CS_W-1:0]       sel;
    logic [READ_WIDTH-1:0] sd;
    int n;
    for (int it = 0; it < 16; it++) begin
      cmd = CMD_WIDTH'($urandom);
      md  = 2'($urandom);
      sel = CS_W'($urandom_range(0, NUM_CS - 1));
      sd  = READ_WIDTH'($urandom);
      n   = model_n(cmd);
      run_frame(cmd, md, sel, sd, 1'b0);
      n_tests++; if (obs_mosi !== model_mosi(cmd)) begin n_fail++; $display("FAIL rnd%0d_mosi: got %h expected %h", it, obs_mosi, model_mosi(cmd)); end
      n_tests++; if (obs_lead !== n || obs_trail !== n) begin n_fail++; $display("FAIL rnd%0d_edges: got %0d/%0d expected %0d", it, obs_lead, obs_trail, n); end
      n_tests++; if (obs_rdy_at !== model_rdy_at(n)) begin n_fail++; $display("FAIL rnd%0d_rdy_at: got %0d expected %0d", it, obs_rdy_at, model_rdy_at(n)); end
      n_tests++; if (obs_cs_low[sel] !== model_cs_low(n)) begin n_fail++; $display("FAIL rnd%0d_cs_low: got %0d expected %0d", it, obs_cs_low[sel], model_cs_low(n)); end
      n_tests++; if (obs_sclk_first !== md[1] || obs_sclk_last !== md[1]) begin n_fail++; $display("FAIL rnd%0d_sclk_idle: got %b/%b expected %b", it, obs_sclk_first, obs_sclk_last, md[1]); end
      n_tests++; if (obs_busy_bad !== 0 || obs_mosi_last !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy_mosi: got %0d/%b expected 0/0", it, obs_busy_bad, obs_mosi_last); end
      if (!cmd[CMD_WIDTH-1]) begin
        exp_rdata = sd;
        n_tests++; if (obs_rvld_cnt !== 1 || obs_rdata !== sd) begin n_fail++; $display("FAIL rnd%0d_read: got %h x%0d expected %h x1", it, obs_rdata, obs_rvld_cnt, sd); end
      end else begin
        n_tests++; if (obs_rvld_cnt !== 0 || bus.read_data !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_write: got %h x%0d expected %h x0", it, bus.read_data, obs_rvld_cnt, exp_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int w;
    int rvld;
    w = 0;
    rvld = 0;
    bus.cmd_in = 12'h0AB; bus.mode = 2'b10; bus.cs_sel = 2'd1; bus.cmd_vld = 1'b1;
    while (bus.cmd_rdy !== 1'b1 && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1 || cs_n[1] !== 1'b0) begin n_fail++; $display("FAIL mid_in_frame: got busy %b cs_n %b expected 1/01", bus.busy, cs_n); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL mid_rst_cs_n: got %b expected 11", cs_n); end
    n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sclk: got %b expected 0", sclk); end
    n_tests++; if (bus.cmd_rdy !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rdy: got %b/%b expected 1/0", bus.cmd_rdy, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (bus.read_vld === 1'b1) rvld++;
    end
    exp_rdata = '0;
    n_tests++; if (rvld !== 0) begin n_fail++; $display("FAIL mid_no_rvld: got %0d expected 0", rvld); end
    n_tests++; if (bus.read_data !== exp_rdata || bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_after: got %h/%b expected 00/1", bus.read_data, bus.cmd_rdy); end
  endtask

  initial begin
    rst_n       = 1'b0;
    miso        = 1'b0;
    bus.cmd_in  = '0;
    bus.cmd_vld = 1'b0;
    bus.mode    = 2'b00;
    bus.cs_sel  = '0;
    exp_rdata   = '0;
    test_reset;
    test_write_mode0;
    test_read_mode0;
    test_mode3_read;
    test_cs_select;
    test_back_to_back;
    test_random;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
